// File: rtl/trigger_queue_pkg.sv
// Shared types and default constants for the trigger event queue.
package trigger_queue_pkg;

    typedef enum logic [1:0] {
        IRQ_IDLE    = 2'd0,
        IRQ_PENDING = 2'd1,
        IRQ_ASSERT  = 2'd2
    } irq_state_e;

    localparam int DEF_DEPTH       = 16;
    localparam int DEF_DATA_W      = 16;
    localparam int DEF_TS_W        = 32;
    localparam int DEF_IRQ_THRESH  = 8;
    localparam int DEF_IRQ_TIMEOUT = 1024;

    localparam int ENTRY_W = DEF_TS_W + DEF_DATA_W;

endpackage

// File: rtl/trig_sync_fifo.sv
// Single-clock FIFO, distributed-RAM storage, combinational head read (read-first).
module trig_sync_fifo #(
    parameter int DEPTH = 16,
    parameter int W     = 48
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [W-1:0]               din,
    output logic [W-1:0]               dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;

    // Extra pointer MSB distinguishes full from empty when the index bits match.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= din;
    end

    assign dout  = mem[rd_ptr[AW-1:0]];
    assign count = wr_ptr - rd_ptr;
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (count == (AW+1)'(DEPTH));

endmodule

// File: rtl/trigger_event_queue.sv
// Timestamps trigger beats, queues them for a backpressured reader, and
// raises a coalesced level interrupt; overflowing beats are counted.
module trigger_event_queue
    import trigger_queue_pkg::*;
#(
    parameter int DEPTH       = DEF_DEPTH,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int TS_W        = DEF_TS_W,
    parameter int IRQ_THRESH  = DEF_IRQ_THRESH,
    parameter int IRQ_TIMEOUT = DEF_IRQ_TIMEOUT
) (
    input  logic                       SYS_CLK,
    input  logic                       RST,
    input  logic                       trigger_axis_tvalid,
    input  logic [DATA_W-1:0]          trigger_axis_tdata,
    output logic                       trigger_axis_tready,
    output logic                       out_axis_tvalid,
    output logic [TS_W+DATA_W-1:0]     out_axis_tdata,
    input  logic                       out_axis_tready,
    output logic                       irq,
    output logic [$clog2(DEPTH):0]     count,
    output logic [15:0]                drop_cnt,
    input  logic                       clr_drop
);

    localparam int EW = TS_W + DATA_W;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int TW = $clog2(IRQ_TIMEOUT) + 1;

    logic [TS_W-1:0] ts;
    logic            full;
    logic            empty;
    logic            pop;
    logic            push_ok;
    logic            drop;
    logic [CW-1:0]   cnt_nxt;

    irq_state_e      state, state_nxt;
    logic [TW-1:0]   timer, timer_nxt;

    always_ff @(posedge SYS_CLK) begin
        if (RST) ts <= '0;
        else     ts <= ts + 1'b1;
    end

    // The upstream ignores tready: a full queue still frees a slot on a same-cycle pop.
    assign pop     = out_axis_tvalid && out_axis_tready;
    assign push_ok = trigger_axis_tvalid && !RST && (!full || pop);
    assign drop    = trigger_axis_tvalid && !RST && full && !pop;

    trig_sync_fifo #(
        .DEPTH (DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk   (SYS_CLK),
        .rst   (RST),
        .push  (push_ok),
        .pop   (pop),
        .din   ({ts, trigger_axis_tdata}),
        .dout  (out_axis_tdata),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    assign trigger_axis_tready = !RST;
    assign out_axis_tvalid     = !empty && !RST;

    always_ff @(posedge SYS_CLK) begin
        if (RST || clr_drop)                drop_cnt <= '0;
        else if (drop && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 1'b1;
    end

    // FSM decisions look at occupancy after this cycle's push/pop.
    assign cnt_nxt = count + CW'(push_ok) - CW'(pop);

    always_comb begin
        state_nxt = state;
        timer_nxt = timer;
        case (state)
            IRQ_IDLE: begin
                if (cnt_nxt >= CW'(IRQ_THRESH)) begin
                    state_nxt = IRQ_ASSERT;
                end else if (cnt_nxt != '0) begin
                    state_nxt = IRQ_PENDING;
                    timer_nxt = '0;
                end
            end
            IRQ_PENDING: begin
                if (cnt_nxt == '0)
                    state_nxt = IRQ_IDLE;
                else if (cnt_nxt >= CW'(IRQ_THRESH) || timer == TW'(IRQ_TIMEOUT - 1))
                    state_nxt = IRQ_ASSERT;
                else
                    timer_nxt = timer + 1'b1;
            end
            IRQ_ASSERT: begin
                if (cnt_nxt == '0) state_nxt = IRQ_IDLE;
            end
            default: state_nxt = IRQ_IDLE;
        endcase
    end

    always_ff @(posedge SYS_CLK) begin
        if (RST) begin
            state <= IRQ_IDLE;
            timer <= '0;
        end else begin
            state <= state_nxt;
            timer <= timer_nxt;
        end
    end

    assign irq = (state == IRQ_ASSERT) && !RST;

endmodule

// File: tb/tb_trigger_event_queue.sv
// Directed bench for trigger_event_queue: vector table plus hand-written corner sequences.
module tb_trigger_event_queue;

    logic        SYS_CLK = 1'b0;
    logic        RST;
    logic        trigger_axis_tvalid;
    logic [15:0] trigger_axis_tdata;
    logic        trigger_axis_tready;
    logic        out_axis_tvalid;
    logic [47:0] out_axis_tdata;
    logic        out_axis_tready;
    logic        irq;
    logic [4:0]  count;
    logic [15:0] drop_cnt;
    logic        clr_drop;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always #5 SYS_CLK = ~SYS_CLK;

    trigger_event_queue dut (
        .SYS_CLK             (SYS_CLK),
        .RST                 (RST),
        .trigger_axis_tvalid (trigger_axis_tvalid),
        .trigger_axis_tdata  (trigger_axis_tdata),
        .trigger_axis_tready (trigger_axis_tready),
        .out_axis_tvalid     (out_axis_tvalid),
        .out_axis_tdata      (out_axis_tdata),
        .out_axis_tready     (out_axis_tready),
        .irq                 (irq),
        .count               (count),
        .drop_cnt            (drop_cnt),
        .clr_drop            (clr_drop)
    );

    typedef struct {
        logic        vld;
        logic [15:0] data;
        logic [4:0]  exp_count;
        logic [15:0] exp_drop;
    } vec_t;

    vec_t tbl [20];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h expected=%h", nm, act, exp);
        end
    endtask

    // Inputs are driven and outputs sampled 1ns after the rising edge.
    task automatic tick();
        @(posedge SYS_CLK);
        #1;
        cyc++;
    endtask

    initial begin
        logic        bad_irq, bad_hold, bad_cnt, bad_drop;
        logic [31:0] prev_ts;
        logic [15:0] exp_pl;

        for (int i = 0; i < 20; i++)
            tbl[i] = '{1'b1, 16'(16'h0101 + i), 5'((i < 16) ? i + 1 : 16), 16'((i < 16) ? 0 : i - 15)};

        RST = 1'b1; trigger_axis_tvalid = 1'b0; trigger_axis_tdata = '0;
        out_axis_tready = 1'b0; clr_drop = 1'b0;
        repeat (3) tick();
        chk("rst_tready", trigger_axis_tready, 0);
        chk("rst_tvalid", out_axis_tvalid, 0);

        // 1: idle after reset
        RST = 1'b0; cyc = 0;
        #1;
        chk("tready_after_rst", trigger_axis_tready, 1);
        repeat (10) tick();
        chk("idle_irq", irq, 0);
        chk("idle_tvalid", out_axis_tvalid, 0);
        chk("idle_count", count, 0);
        chk("idle_drop", drop_cnt, 0);

        // 2: single beat at timestamp 0x20, timeout IRQ
        while (cyc != 32) tick();
        trigger_axis_tvalid = 1'b1; trigger_axis_tdata = 16'h00A5;
        tick();
        trigger_axis_tvalid = 1'b0;
        chk("single_tvalid", out_axis_tvalid, 1);
        chk("single_tdata", out_axis_tdata, {32'h0000_0020, 16'h00A5});
        chk("single_irq0", irq, 0);
        bad_irq = 1'b0; bad_hold = 1'b0;
        for (int k = 0; k < 1023; k++) begin
            tick();
            if (irq !== 1'b0) bad_irq = 1'b1;
            if (out_axis_tdata !== {32'h0000_0020, 16'h00A5} || out_axis_tvalid !== 1'b1) bad_hold = 1'b1;
        end
        chk("irq_not_early", bad_irq, 0);
        chk("head_stable", bad_hold, 0);
        tick();
        chk("irq_timeout", irq, 1);
        out_axis_tready = 1'b1;
        tick();
        out_axis_tready = 1'b0;
        chk("pop_count", count, 0);
        chk("pop_irq", irq, 0);
        chk("pop_tvalid", out_axis_tvalid, 0);

        // 3: eight beats reach threshold
        for (int i = 1; i <= 8; i++) begin
            trigger_axis_tvalid = 1'b1; trigger_axis_tdata = 16'(i);
            tick();
            if (i == 7) chk("irq_below_thresh", irq, 0);
        end
        trigger_axis_tvalid = 1'b0;
        chk("thresh_count", count, 8);
        chk("thresh_irq", irq, 1);
        out_axis_tready = 1'b1;
        prev_ts = '0;
        for (int i = 1; i <= 8; i++) begin
            chk("drain_payload", out_axis_tdata[15:0], 64'(i));
            chk("drain_ts_incr", out_axis_tdata[47:16] > prev_ts, 1);
            prev_ts = out_axis_tdata[47:16];
            tick();
        end
        out_axis_tready = 1'b0;
        chk("drain_count", count, 0);
        chk("drain_irq", irq, 0);

        // 4: overflow by table
        for (int i = 0; i < 20; i++) begin
            trigger_axis_tvalid = tbl[i].vld; trigger_axis_tdata = tbl[i].data;
            tick();
            chk("ovf_count", count, tbl[i].exp_count);
            chk("ovf_drop", drop_cnt, tbl[i].exp_drop);
        end
        trigger_axis_tvalid = 1'b0;
        out_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("ovf_readout", out_axis_tdata[15:0], 64'(16'h0101 + i));
            tick();
        end
        out_axis_tready = 1'b0;
        chk("ovf_no_extra", out_axis_tvalid, 0);
        chk("ovf_drop_kept", drop_cnt, 4);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        chk("clr_drop", drop_cnt, 0);

        // 5: full queue with concurrent push/pop, clear-vs-drop, saturation
        for (int i = 0; i < 16; i++) begin
            trigger_axis_tvalid = 1'b1; trigger_axis_tdata = 16'(16'h0201 + i);
            tick();
        end
        chk("full_count", count, 16);
        trigger_axis_tdata = 16'hDEAD;
        tick();
        chk("full_drop1", drop_cnt, 1);
        clr_drop = 1'b1;
        tick();
        clr_drop = 1'b0;
        chk("clr_beats_drop", drop_cnt, 0);
        out_axis_tready = 1'b1;
        bad_cnt = 1'b0; bad_drop = 1'b0;
        for (int k = 0; k < 20; k++) begin
            exp_pl = (k < 16) ? 16'(16'h0201 + k) : 16'(16'h0300 + k - 16);
            chk("stream_head", out_axis_tdata[15:0], 64'(exp_pl));
            trigger_axis_tdata = 16'(16'h0300 + k);
            tick();
            if (count !== 5'd16) bad_cnt = 1'b1;
            if (drop_cnt !== 16'd0) bad_drop = 1'b1;
        end
        chk("stream_count16", bad_cnt, 0);
        chk("stream_no_drop", bad_drop, 0);
        out_axis_tready = 1'b0;
        repeat (70000) tick();
        trigger_axis_tvalid = 1'b0;
        chk("drop_saturate", drop_cnt, 16'hFFFF);

        // 6: reset mid-operation
        out_axis_tready = 1'b1;
        repeat (11) tick();
        out_axis_tready = 1'b0;
        chk("pre_rst_count", count, 5);
        chk("pre_rst_irq", irq, 1);
        RST = 1'b1;
        tick();
        chk("rst_count", count, 0);
        chk("rst_irq", irq, 0);
        chk("rst_tvalid2", out_axis_tvalid, 0);
        chk("rst_drop", drop_cnt, 0);
        RST = 1'b0; cyc = 0;
        trigger_axis_tvalid = 1'b1; trigger_axis_tdata = 16'h0077;
        tick();
        trigger_axis_tvalid = 1'b0;
        chk("post_rst_ts", out_axis_tdata, {32'h0, 16'h0077});
        chk("post_rst_count", count, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/trigger_event_queue.md
Name: trigger_event_queue

Overview:
- Sits directly downstream of the core control plane's trigger AXI-Stream output.
- The control plane ignores tready, so this block must absorb every beat. It timestamps each 16-bit trigger, buffers it, and presents it to the PRM-side reader on a backpressured AXI-Stream.
- Raises a coalesced interrupt to that reader and counts any triggers lost to overflow.

Parameters:
- DEPTH, 16, FIFO entries; power of two, 4..256.
- DATA_W, 16, trigger payload width.
- TS_W, 32, timestamp width.
- IRQ_THRESH, 8, occupancy at or above which IRQ asserts immediately; 1..DEPTH.
- IRQ_TIMEOUT, 1024, cycles a non-empty, below-threshold queue waits before IRQ asserts; must be ≥1.

Ports:
- SYS_CLK  in  1  clock.
- RST  in  1  reset; synchronous, active-high.
- trigger_axis_tvalid  in  1  trigger beat valid, from the control plane.
- trigger_axis_tdata  in  DATA_W  trigger payload.
- trigger_axis_tready  out  1  constant 1 outside reset; informational only.
- out_axis_tvalid  out  1  queue head valid.
- out_axis_tdata  out  TS_W+DATA_W  {timestamp, payload}; timestamp in the MSBs.
- out_axis_tready  in  1  reader accepts head.
- irq  out  1  level interrupt.
- count  out  clog2(DEPTH)+1  current occupancy.
- drop_cnt  out  16  saturating count of overflow drops.
- clr_drop  in  1  one-cycle pulse; clears drop_cnt.

Behaviour:
- Reset (RST high at a SYS_CLK edge):
  - timestamp=0, pointers=0, count=0, drop_cnt=0, FSM=IDLE, timer=0.
  - irq=0, out_axis_tvalid=0, trigger_axis_tready=0 while RST is high.
  - Stored entries are discarded. Reset mid-operation loses the queue contents without error.
- Timestamp:
  - Free-running TS_W counter, +1 every cycle, wraps from all-ones to 0.
  - A beat captures the counter value of its accept cycle.
- Push:
  - Push when trigger_axis_tvalid=1 and RST=0.
  - Accepted if count<DEPTH, or count==DEPTH with a pop in the same cycle.
  - Otherwise the beat is dropped and drop_cnt increments, saturating at 0xFFFF.
- Pop:
  - Pop when out_axis_tvalid && out_axis_tready.
  - out_axis_tvalid = (count!=0). out_axis_tdata = mem[rd_ptr], combinational read.
  - Head and tdata stay stable while tvalid=1 and tready=0.
- Latency: a beat accepted in cycle N into an empty queue is visible on out_axis in cycle N+1. No same-cycle fall-through.
- Simultaneous push and pop:
  - count unchanged; both pointers advance.
  - Pointers wrap modulo DEPTH, with an extra MSB to tell full from empty.
- clr_drop coinciding with a drop: clear wins; drop_cnt=0.
- IRQ FSM (registered; irq = state==ASSERT):
  - IDLE: count≥IRQ_THRESH → ASSERT. Else count>0 → PENDING, timer=0.
  - PENDING: count==0 → IDLE. count≥IRQ_THRESH or timer==IRQ_TIMEOUT-1 → ASSERT. Else timer++.
  - ASSERT: count==0 → IDLE. Otherwise hold; irq drops only when the queue is drained.
  - Occupancy checks use the count value after the current cycle's push/pop. irq therefore rises the cycle after the triggering occupancy change.
- Widths: count is clog2(DEPTH)+1 bits and must represent DEPTH exactly. The IRQ timer is clog2(IRQ_TIMEOUT)+1 bits.

Decomposition:
- Shared package trigger_queue_pkg:
  - IRQ state encoding: IDLE=0, PENDING=1, ASSERT=2.
  - Entry-width constant ENTRY_W = TS_W+DATA_W.
  - Default parameter constants.
- One sub-module, trig_sync_fifo: a parameterised single-clock FIFO with read-first, distributed-RAM storage, push/pop/full/empty/count.
- The top level holds the timestamp counter, the drop counter and the IRQ FSM.

Test Plan:
1. Reset then idle 10 cycles → irq=0, out_axis_tvalid=0, count=0, drop_cnt=0; trigger_axis_tready=1 from the first cycle after RST falls.
2. Single beat tdata=0x00A5 at timestamp 0x20, out_axis_tready=0 → next cycle tvalid=1, tdata={0x00000020,0x00A5}, held stable. irq rises exactly IRQ_TIMEOUT (1024) cycles after PENDING entry. Raise tready for one cycle → count=0, irq=0 the following cycle.
3. Eight back-to-back beats 0x0001..0x0008, tready=0 → count=8, irq=1 one cycle after the 8th push. Drain reads back payloads in order 1..8 with strictly increasing timestamps.
4. Push 20 beats with tready=0 → count=16, drop_cnt=4. Beats 17..20 are absent on readout. clr_drop pulse → drop_cnt=0.
5. Full queue, continuous tvalid and tready=1 → no drops, count stays 16, one pop per cycle. Then 70000 drops with tready=0 → drop_cnt=0xFFFF, saturated.
6. Assert RST mid-burst with count=5 and irq=1 → next cycle count=0, irq=0, tvalid=0. Post-reset timestamps restart at 0.
